// File: rtl/ram_pkg.sv
// Shared widths and request/response bundles for the RAM request front-end.
package ram_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int RSP_DEPTH  = 4;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
  } ram_rsp_t;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Response FIFO holding captured RAM read data until the consumer takes it.
module ram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);
  import ram_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] last_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign pop_ok_s  = pop & (count_r != {CW{1'b0}});
  assign push_ok_s = push & ((count_r != CW'(DEPTH)) | pop_ok_s);
  assign count     = count_r;

  // Storage array: write-only path, no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and last-popped word; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      last_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
        last_r   <= mem_r[rd_ptr_r];
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head of queue when occupied, otherwise the last value handed out.
  always_comb begin
    pop_data = last_r;
    if (count_r != {CW{1'b0}}) begin
      pop_data = mem_r[rd_ptr_r];
    end else begin
      pop_data = last_r;
    end
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// Valid/ready front-end for a single-port RAM with one-cycle registered read;
// read data is queued in order so the consumer can backpressure.
module ram_req_ctrl #(
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int RSP_DEPTH  = ram_pkg::RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);
  import ram_pkg::*;

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic          inflight_r;
  logic [CW-1:0] count_s;
  logic [CW:0]   credit_s;
  logic          fire_s;
  logic          pop_s;

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign credit_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};

  // Accept only while every outstanding read is guaranteed a slot; held off in reset.
  always_comb begin
    req_ready = 1'b0;
    if (rst && (credit_s < (CW+1)'(RSP_DEPTH))) begin
      req_ready = 1'b1;
    end else begin
      req_ready = 1'b0;
    end
  end

  assign fire_s      = req_valid & req_ready;
  assign ram_we      = fire_s & req_we;
  assign ram_addr    = req_addr;
  assign ram_data_in = req_wdata;

  assign rsp_valid = (count_s != {CW{1'b0}});
  assign pop_s     = rsp_valid & rsp_ready;
  assign busy      = inflight_r | rsp_valid;

  // Marks the cycle in which the RAM presents data for the previous read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= fire_s & ~req_we;
    end
  end

  ram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data (ram_data_out),
    .pop       (pop_s),
    .pop_data  (rsp_rdata),
    .count     (count_s)
  );

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl: behavioural RAM, queue-based reference model
// compared every cycle, plus literal expectations per scenario.
module tb_ram_req_ctrl;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_we;
  logic [DW-1:0] ram_data_out;
  logic          busy;

  always #5 clk = ~clk;

  ram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_data_out(ram_data_out), .busy(busy)
  );

  function automatic logic [31:0] init_val(int i);
    if (i == 32) return 32'h0000_0005;
    return 32'hA000_0000 | 32'(i);
  endfunction

  // Behavioural single-port RAM with registered read (read-before-write).
  logic [DW-1:0] ram_mem [0:255];
  logic          load_en = 1'b1;
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
    end else if (ram_we) begin
      ram_mem[ram_addr[7:0]] <= ram_data_in;
    end
    ram_data_out <= ram_mem[ram_addr[7:0]];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each accepted, unpopped read is one queue entry that
  // becomes visible two cycles after acceptance.
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t          q[$];
  logic [31:0]   ref_mem [0:255];
  int            cyc = 0;

  initial begin
    logic exp_rdy, exp_fire, exp_valid;
    exp_t e;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
      end else begin
        exp_rdy   = (q.size() < DEPTH);
        exp_fire  = req_valid & exp_rdy;
        exp_valid = (q.size() > 0) && (q[0].due <= cyc);
        chk("req_ready", req_ready, exp_rdy);
        chk("ram_we", ram_we, exp_fire & req_we);
        chk("rsp_valid", rsp_valid, exp_valid);
        chk("busy", busy, q.size() != 0);
        chk("ram_addr", ram_addr, req_addr);
        chk("ram_data_in", ram_data_in, req_wdata);
        if (exp_valid) chk("rsp_rdata", rsp_rdata, q[0].data);
        if (exp_valid && rsp_ready) void'(q.pop_front());
        if (exp_fire) begin
          if (req_we) begin
            ref_mem[req_addr[7:0]] = req_wdata;
          end else begin
            e.data = ref_mem[req_addr[7:0]];
            e.due  = cyc + 2;
            q.push_back(e);
          end
        end
      end
      cyc++;
    end
  end

  // Per-step observations for the directed scenarios.
  logic        s_rdy, s_fire, s_we, s_busy;
  logic [31:0] got[$];
  int          tick = 0;

  task automatic step(input logic v, input logic we, input logic [15:0] a, input logic [31:0] d);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    s_rdy  = req_ready;
    s_fire = v & req_ready;
    s_we   = ram_we;
    s_busy = busy;
    if (rsp_valid && rsp_ready) got.push_back(rsp_rdata);
    tick++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int we_cnt, nfire, rtick, lat;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    load_en = 1'b0;
    rst = 1'b1;

    // 1: ready on the first cycle after release
    step(1'b0, 1'b0, 16'h0, 32'h0);
    chk("t1_ready_after_release", s_rdy, 1);

    // 2: write then read back, 2-cycle latency
    got.delete(); we_cnt = 0; lat = -1;
    step(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    we_cnt += int'(s_we);
    rsp_ready = 1'b1;
    step(1'b1, 1'b0, 16'h0010, 32'h0);
    chk("t2_read_fire", s_fire, 1);
    we_cnt += int'(s_we);
    rtick = tick - 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'h0, 32'h0);
      we_cnt += int'(s_we);
      if (got.size() > 0 && lat < 0) lat = tick - 1 - rtick;
    end
    chk("t2_latency", lat, 2);
    chk("t2_rdata", (got.size() > 0) ? got[0] : 32'h0, 32'hDEADBEEF);
    chk("t2_we_cycles", we_cnt, 1);

    // 3: back-to-back reads 0..7
    got.delete(); nfire = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 16'(i), 32'h0);
      nfire += int'(s_fire);
    end
    repeat (4) step(1'b0, 1'b0, 16'h0, 32'h0);
    chk("t3_fires", nfire, 8);
    chk("t3_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("t3_rsp%0d", i), got[i], 32'hA000_0000 + 32'(i));

    // 4: backpressure fills credit, write also stalled
    rsp_ready = 1'b0; got.delete(); nfire = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 16'(8 + i), 32'h0);
      nfire += int'(s_fire);
    end
    chk("t4_accepted", nfire, 4);
    step(1'b1, 1'b1, 16'h0030, 32'h0000_0077);
    chk("t4_write_stalled", s_fire, 0);
    chk("t4_ram_we_low", s_we, 0);
    rsp_ready = 1'b1;
    step(1'b0, 1'b0, 16'h0, 32'h0);
    chk("t4_ready_at_first_pop", s_rdy, 0);
    step(1'b0, 1'b0, 16'h0, 32'h0);
    chk("t4_ready_after_pop", s_rdy, 1);
    repeat (4) step(1'b0, 1'b0, 16'h0, 32'h0);
    chk("t4_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("t4_rsp%0d", i), got[i], 32'hA000_0008 + 32'(i));

    // 5: reset right after a read fires discards it
    got.delete();
    step(1'b1, 1'b0, 16'h0003, 32'h0);
    chk("t5_read_fire", s_fire, 1);
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 16'h0, 32'h0);
    rst = 1'b1;
    repeat (5) step(1'b0, 1'b0, 16'h0, 32'h0);
    chk("t5_no_response", got.size(), 0);
    chk("t5_idle_after_release", s_busy, 0);

    // 6: read then write same address returns old data
    got.delete();
    step(1'b1, 1'b0, 16'h0020, 32'h0);
    step(1'b1, 1'b1, 16'h0020, 32'h0000_0001);
    repeat (3) step(1'b0, 1'b0, 16'h0, 32'h0);
    step(1'b1, 1'b0, 16'h0020, 32'h0);
    repeat (3) step(1'b0, 1'b0, 16'h0, 32'h0);
    chk("t6_count", got.size(), 2);
    chk("t6_old", (got.size() > 0) ? got[0] : 32'hFFFF_FFFF, 32'h0000_0005);
    chk("t6_new", (got.size() > 1) ? got[1] : 32'hFFFF_FFFF, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
- Request front-end directly upstream of the single-port synchronous RAM (16-bit word address, 32-bit data, 1-cycle registered read, write-enable).
- Converts a valid/ready request channel into RAM addr/we/data_in drive.
- Captures the RAM's one-cycle read data into a response FIFO so consumers may backpressure.
- Returns read responses strictly in request order.

Parameters:
- ADDR_WIDTH, 16, RAM word-address width
- DATA_WIDTH, 32, data width
- RSP_DEPTH, 4, response FIFO entries; power of two, >= 2 (>= 3 needed for 1 read/cycle sustained)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when valid&ready (fire)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_WIDTH  read data
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_data_in  out  DATA_WIDTH  to RAM data_in
- ram_we  out  1  to RAM we
- ram_data_out  in  DATA_WIDTH  from RAM data_out (registered, valid cycle after addr)
- busy  out  1  read in flight or FIFO non-empty

Behaviour:
- rst low: FIFO emptied (count=0, pointers=0), inflight=0; outputs forced: req_ready=0, rsp_valid=0, ram_we=0, busy=0; rsp_rdata=0. Reset asserted mid-operation discards in-flight read and all queued responses; no response produced after release for pre-reset requests.
- req_ready = (count + inflight) < RSP_DEPTH; independent of req_we, req_valid, rsp_ready (no combinational path from rsp_ready).
- ram_addr = req_addr, ram_data_in = req_wdata (combinational pass-through).
- ram_we = fire & req_we.
- Write: completes at the fire edge; produces no response.
- Read at cycle N: inflight<=1. At cycle N+1, ram_data_out is pushed into the FIFO at the N+1 edge; rsp_valid=1 from cycle N+2 (fixed 2-cycle minimum latency, no bypass).
- inflight next = fire & ~req_we; the push in the same cycle is always accepted (credit guarantees space).
- Pop: rsp_valid & rsp_ready; simultaneous push and pop leaves count unchanged.
- FIFO full (count==RSP_DEPTH) while holding responses: req_ready=0 for both reads and writes until a pop. Overflow is impossible by construction; the bench asserts it.
- Empty: rsp_valid=0 and rsp_rdata holds the last popped value (don't care).
- Pointers wrap modulo RSP_DEPTH. Count is a log2(RSP_DEPTH)+1-bit field.
- Read then write to the same address in consecutive cycles: the read returns old data.
- Ordering: responses return in accepted-read order; writes never reorder reads.
- busy = inflight | (count != 0).

Decomposition:
- Package ram_pkg: ADDR_WIDTH/DATA_WIDTH defaults; ram_req_t struct {we, addr, wdata}; ram_rsp_t {rdata}.
- One sub-module: ram_rsp_fifo (synchronous FIFO with parameterised depth, push/pop/count, async active-low reset).
- Credit and inflight logic stay in ram_req_ctrl.

Test Plan:
1. Reset (rst=0 for 3 cycles, then 1) -> req_ready=0, rsp_valid=0, ram_we=0, busy=0 during reset; req_ready=1 on the first cycle after release.
2. Write 0x0010<-0xDEADBEEF, then read 0x0010 with rsp_ready=1 -> ram_we high exactly 1 cycle; rsp_valid rises 2 cycles after read fire with rsp_rdata=0xDEADBEEF.
3. Back-to-back reads 0..7 every cycle, rsp_ready=1, RSP_DEPTH=4 -> req_ready stays 1; 8 responses in order, 1 per cycle, matching preloaded data.
4. rsp_ready=0, issue reads continuously -> exactly 4 reads accepted, then req_ready=0 (a concurrent write is also stalled). Raise rsp_ready -> 4 ordered responses; req_ready reasserts the cycle after the first pop.
5. Read fires, rst pulled low the next cycle -> no rsp_valid ever for that read; FIFO count=0 after release.
6. Read 0x0020 and write 0x0020<-0x1 on consecutive cycles (old value 0x5) -> response 0x5; a later read returns 0x1.
